char_text_buffer: RTL and testbench
===================================

// Module: char_text_buffer
// PURPOSE
// - Text source for the 16x16-cell character overlay: 256-cell text RAM + font lookup.
// - Upstream of the character overlay stage. Takes its registered char_xy {row[7:4],col[3:0]}
//   and char_line, and returns the 8-pixel font row char_pixel one clock later.
// - Game/UI logic writes text via a valid/ready byte stream with an auto-advancing cursor.
// PARAMETERS
// - FILL_CHAR   8'h20  code written into every cell by clear (reset or FF)
// - TAB_WIDTH   4      column alignment for HT (power of 2, <=16)
// PORTS
// - clk65MHz    in   1  pixel clock
// - rst         in   1  synchronous, active-high reset
// - char_xy     in   8  cell address from overlay stage: [7:4] row, [3:0] column
// - char_line   in   4  scan line inside cell, 0..15
// - char_pixel  out  8  font row; bit7 = leftmost pixel
// - wr_valid    in   1  write request; wr_char held stable while valid && !ready
// - wr_char     in   8  printable code or control code
// - wr_ready    out  1  accepts a byte this cycle when high
// - cursor_xy   out  8  next write cell {row,col}
// - busy        out  1  clear sequence in progress
// BEHAVIOUR
// - Reset values: char_pixel=0, cursor_xy=0, wr_ready=0, busy=1.
//   Reset enters CLEAR; the RAM itself is not reset.
// - FSM states: CLEAR -> IDLE.
//   - CLEAR: clr_addr counts 0..255 and writes FILL_CHAR once per clock (256 cycles).
//     busy=1, wr_ready=0 throughout.
//   - At clr_addr==255: go to IDLE on the next clock, cursor_xy=0.
//   - IDLE: wr_ready=1, busy=0. A byte is accepted on any clock with wr_valid && wr_ready.
// - Effect of an accepted byte, decided on the acceptance clock:
//   - 0x20..0x7E: RAM[cursor] <= code, then cursor+1.
//     col 15 -> col 0 of row+1; cell 0xFF -> 0x00 (wraps, no scroll).
//   - 0x0A LF: col=0, row=row+1 (row 15 -> 0). No RAM write.
//   - 0x0D CR: col=0. No RAM write.
//   - 0x08 BS: cursor-1 (0x00 -> 0xFF), RAM[new cursor] <= FILL_CHAR. Same clock.
//   - 0x09 HT: col = next multiple of TAB_WIDTH. Overflow past col 15 acts as LF.
//   - 0x0C FF: enter CLEAR. wr_ready drops on the following clock.
//   - Any other code: accepted and ignored. Cursor and RAM unchanged.
// - Read path:
//   - Text RAM read is asynchronous (distributed): code = RAM[char_xy].
//   - Font address = {code[6:0], char_line} (11 bits).
//   - char_pixel is registered: latency exactly 1 clock from char_xy/char_line.
//     No other pipeline stage.
//   - Read runs in every state. During CLEAR, cells already cleared read as FILL_CHAR.
// - Read and write to the same cell on the same clock: char_pixel uses the old code
//   (read-before-write). The new code is visible from the next clock.
// - rst asserted mid-write or mid-CLEAR: the in-flight byte is lost and CLEAR restarts at 0.
// - Codes >=0x80 are never stored; they are ignored like other non-printables.
// STRUCTURE
// - char_pkg (shared):
//   - typedef enum logic {CLEAR, IDLE} txt_state_t
//   - localparams CC_BS=8'h08, CC_HT=8'h09, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D
//   - localparams CELL_W=8, CELL_H=16, TEXT_COLS=16, TEXT_ROWS=16
// - Sub-module font_rom: 2048x8 combinational ROM, address {code[6:0], line[3:0]}.
//   Code 0x20 rows are all 0.
// - Top level holds: text RAM (logic [7:0] mem[256]), FSM, cursor, clr_addr, char_pixel register.
// TESTING
// - Reset, then 256 clocks: busy=1, wr_ready=0.
//   On clock 257: busy=0, wr_ready=1, cursor_xy=0x00.
//   Every cell with char_line=0..15 reads char_pixel=0x00.
// - Write 'A' (0x41) at cursor 0x00: cursor_xy=0x01.
//   char_xy=0x00, char_line=5 -> char_pixel equals font_rom[{7'h41,4'd5}] exactly 1 clock later.
// - 17 writes of 'B', then LF: last 'B' lands in cell 0x10, cursor_xy=0x20.
//   CR from 0x2A -> 0x20. HT from 0x21 -> 0x24. HT from 0x2D -> 0x30.
// - Cursor at 0xFF, write 'C': cell 0xFF='C', cursor_xy=0x00.
//   Then BS: cursor_xy=0xFF, cell 0xFF=0x20.
// - Hold wr_valid=1 with wr_char=FF (0x0C) for one accept, then 0x41 stream:
//   no write is accepted for the next 256 clocks; the first 'A' lands in cell 0x00 afterwards.
// - Same-clock write of 'Z' to cell 0x33 while char_xy=0x33:
//   char_pixel shows the old glyph, 'Z' from the next clock.
//   rst pulsed during CLEAR at clr_addr=100 -> CLEAR restarts and lasts a full 256 clocks.

Source files
------------

// File: rtl/char_pkg.sv
// Shared types and constants for the character text buffer.
// Control codes, text geometry and the printable-range helper.
package char_pkg;

    typedef enum logic {CLEAR, IDLE} txt_state_t;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_HT = 8'h09;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    localparam int CELL_W    = 8;
    localparam int CELL_H    = 16;
    localparam int TEXT_COLS = 16;
    localparam int TEXT_ROWS = 16;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/font_rom.sv
// 2048x8 combinational font ROM, address {code[6:0], line[3:0]}.
// 5x7 glyphs sit on lines 4..10, one column in from the left edge.
module font_rom
    import char_pkg::*;
(
    input  logic [10:0]       addr,
    output logic [CELL_W-1:0] data
);

    localparam logic [3:0] GLYPH_TOP = 4'd4;

    logic [55:0] glyph;
    logic [3:0]  rel;
    logic [5:0]  base;

    function automatic logic [55:0] glyph_bits(input logic [6:0] c);
        case (c)
            7'h20: glyph_bits = 56'h00_00_00_00_00_00_00;
            7'h21: glyph_bits = 56'h04_04_04_04_00_00_04;
            7'h22: glyph_bits = 56'h0A_0A_0A_00_00_00_00;
            7'h23: glyph_bits = 56'h0A_0A_1F_0A_1F_0A_0A;
            7'h24: glyph_bits = 56'h04_0F_14_0E_05_1E_04;
            7'h25: glyph_bits = 56'h18_19_02_04_08_13_03;
            7'h26: glyph_bits = 56'h0C_12_14_08_15_12_0D;
            7'h27: glyph_bits = 56'h0C_04_08_00_00_00_00;
            7'h28: glyph_bits = 56'h02_04_08_08_08_04_02;
            7'h29: glyph_bits = 56'h08_04_02_02_02_04_08;
            7'h2A: glyph_bits = 56'h00_04_15_0E_15_04_00;
            7'h2B: glyph_bits = 56'h00_04_04_1F_04_04_00;
            7'h2C: glyph_bits = 56'h00_00_00_00_0C_04_08;
            7'h2D: glyph_bits = 56'h00_00_00_1F_00_00_00;
            7'h2E: glyph_bits = 56'h00_00_00_00_00_0C_0C;
            7'h2F: glyph_bits = 56'h00_01_02_04_08_10_00;
            7'h30: glyph_bits = 56'h0E_11_13_15_19_11_0E;
            7'h31: glyph_bits = 56'h04_0C_04_04_04_04_0E;
            7'h32: glyph_bits = 56'h0E_11_01_02_04_08_1F;
            7'h33: glyph_bits = 56'h1F_02_04_02_01_11_0E;
            7'h34: glyph_bits = 56'h02_06_0A_12_1F_02_02;
            7'h35: glyph_bits = 56'h1F_10_1E_01_01_11_0E;
            7'h36: glyph_bits = 56'h06_08_10_1E_11_11_0E;
            7'h37: glyph_bits = 56'h1F_01_02_04_08_08_08;
            7'h38: glyph_bits = 56'h0E_11_11_0E_11_11_0E;
            7'h39: glyph_bits = 56'h0E_11_11_0F_01_02_0C;
            7'h3A: glyph_bits = 56'h00_0C_0C_00_0C_0C_00;
            7'h3B: glyph_bits = 56'h00_0C_0C_00_0C_04_08;
            7'h3C: glyph_bits = 56'h02_04_08_10_08_04_02;
            7'h3D: glyph_bits = 56'h00_00_1F_00_1F_00_00;
            7'h3E: glyph_bits = 56'h08_04_02_01_02_04_08;
            7'h3F: glyph_bits = 56'h0E_11_01_02_04_00_04;
            7'h40: glyph_bits = 56'h0E_11_01_0D_15_15_0E;
            7'h41: glyph_bits = 56'h0E_11_11_11_1F_11_11;
            7'h42: glyph_bits = 56'h1E_11_11_1E_11_11_1E;
            7'h43: glyph_bits = 56'h0E_11_10_10_10_11_0E;
            7'h44: glyph_bits = 56'h1C_12_11_11_11_12_1C;
            7'h45: glyph_bits = 56'h1F_10_10_1E_10_10_1F;
            7'h46: glyph_bits = 56'h1F_10_10_1E_10_10_10;
            7'h47: glyph_bits = 56'h0E_11_10_17_11_11_0F;
            7'h48: glyph_bits = 56'h11_11_11_1F_11_11_11;
            7'h49: glyph_bits = 56'h0E_04_04_04_04_04_0E;
            7'h4A: glyph_bits = 56'h07_02_02_02_02_12_0C;
            7'h4B: glyph_bits = 56'h11_12_14_18_14_12_11;
            7'h4C: glyph_bits = 56'h10_10_10_10_10_10_1F;
            7'h4D: glyph_bits = 56'h11_1B_15_15_11_11_11;
            7'h4E: glyph_bits = 56'h11_11_19_15_13_11_11;
            7'h4F: glyph_bits = 56'h0E_11_11_11_11_11_0E;
            7'h50: glyph_bits = 56'h1E_11_11_1E_10_10_10;
            7'h51: glyph_bits = 56'h0E_11_11_11_15_12_0D;
            7'h52: glyph_bits = 56'h1E_11_11_1E_14_12_11;
            7'h53: glyph_bits = 56'h0F_10_10_0E_01_01_1E;
            7'h54: glyph_bits = 56'h1F_04_04_04_04_04_04;
            7'h55: glyph_bits = 56'h11_11_11_11_11_11_0E;
            7'h56: glyph_bits = 56'h11_11_11_11_11_0A_04;
            7'h57: glyph_bits = 56'h11_11_11_15_15_15_0A;
            7'h58: glyph_bits = 56'h11_11_0A_04_0A_11_11;
            7'h59: glyph_bits = 56'h11_11_11_0A_04_04_04;
            7'h5A: glyph_bits = 56'h1F_01_02_04_08_10_1F;
            7'h5B: glyph_bits = 56'h0E_08_08_08_08_08_0E;
            7'h5C: glyph_bits = 56'h00_10_08_04_02_01_00;
            7'h5D: glyph_bits = 56'h0E_02_02_02_02_02_0E;
            7'h5E: glyph_bits = 56'h04_0A_11_00_00_00_00;
            7'h5F: glyph_bits = 56'h00_00_00_00_00_00_1F;
            7'h60: glyph_bits = 56'h08_04_02_00_00_00_00;
            7'h61: glyph_bits = 56'h00_00_0E_01_0F_11_0F;
            7'h62: glyph_bits = 56'h10_10_16_19_11_11_1E;
            7'h63: glyph_bits = 56'h00_00_0E_10_10_11_0E;
            7'h64: glyph_bits = 56'h01_01_0D_13_11_11_0F;
            7'h65: glyph_bits = 56'h00_00_0E_11_1F_10_0E;
            7'h66: glyph_bits = 56'h06_09_08_1C_08_08_08;
            7'h67: glyph_bits = 56'h00_0F_11_11_0F_01_0E;
            7'h68: glyph_bits = 56'h10_10_16_19_11_11_11;
            7'h69: glyph_bits = 56'h04_00_0C_04_04_04_0E;
            7'h6A: glyph_bits = 56'h02_00_06_02_02_12_0C;
            7'h6B: glyph_bits = 56'h10_10_12_14_18_14_12;
            7'h6C: glyph_bits = 56'h0C_04_04_04_04_04_0E;
            7'h6D: glyph_bits = 56'h00_00_1A_15_15_11_11;
            7'h6E: glyph_bits = 56'h00_00_16_19_11_11_11;
            7'h6F: glyph_bits = 56'h00_00_0E_11_11_11_0E;
            7'h70: glyph_bits = 56'h00_00_1E_11_1E_10_10;
            7'h71: glyph_bits = 56'h00_00_0D_13_0F_01_01;
            7'h72: glyph_bits = 56'h00_00_16_19_10_10_10;
            7'h73: glyph_bits = 56'h00_00_0E_10_0E_01_1E;
            7'h74: glyph_bits = 56'h08_08_1C_08_08_09_06;
            7'h75: glyph_bits = 56'h00_00_11_11_11_13_0D;
            7'h76: glyph_bits = 56'h00_00_11_11_11_0A_04;
            7'h77: glyph_bits = 56'h00_00_11_11_15_15_0A;
            7'h78: glyph_bits = 56'h00_00_11_0A_04_0A_11;
            7'h79: glyph_bits = 56'h00_00_11_11_0F_01_0E;
            7'h7A: glyph_bits = 56'h00_00_1F_02_04_08_1F;
            7'h7B: glyph_bits = 56'h02_04_04_08_04_04_02;
            7'h7C: glyph_bits = 56'h04_04_04_04_04_04_04;
            7'h7D: glyph_bits = 56'h08_04_04_02_04_04_08;
            7'h7E: glyph_bits = 56'h00_00_08_15_02_00_00;
            default: glyph_bits = 56'h0;
        endcase
    endfunction

    always_comb begin
        glyph = glyph_bits(addr[10:4]);
        rel   = addr[3:0] - GLYPH_TOP;
        base  = {3'd6 - rel[2:0], 3'b000};
        data  = '0;
        if ((addr[3:0] >= GLYPH_TOP) && (rel <= 4'd6))
            data = {1'b0, glyph[base +: 5], 2'b00};
    end

endmodule

// File: rtl/char_text_buffer.sv
// 256-cell text RAM with cursor-driven byte writer and font lookup
// feeding the 16x16 character overlay, one clock of read latency.
module char_text_buffer
    import char_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter int         TAB_WIDTH = 4
)
(
    input  logic              clk65MHz,
    input  logic              rst,
    input  logic [7:0]        char_xy,
    input  logic [3:0]        char_line,
    output logic [CELL_W-1:0] char_pixel,
    input  logic              wr_valid,
    input  logic [7:0]        wr_char,
    output logic              wr_ready,
    output logic [7:0]        cursor_xy,
    output logic              busy
);

    localparam int         CELLS    = TEXT_COLS * TEXT_ROWS;
    localparam logic [7:0] TAB_MASK = 8'(TAB_WIDTH - 1);

    logic [7:0]        mem [CELLS];
    txt_state_t        state;
    logic [7:0]        clr_addr;
    logic              accept;
    logic              mem_we;
    logic [7:0]        mem_waddr;
    logic [7:0]        mem_wdata;
    logic [7:0]        cursor_nxt;
    logic [6:0]        font_code;
    logic [CELL_W-1:0] font_row;

    assign wr_ready = (state == IDLE);
    assign busy     = (state == CLEAR);
    assign accept   = wr_valid && wr_ready;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_addr;
        mem_wdata = FILL_CHAR;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we = 1'b1;
            end else if (accept && is_printable(wr_char)) begin
                mem_we    = 1'b1;
                mem_waddr = cursor_xy;
                mem_wdata = wr_char;
            end else if (accept && (wr_char == CC_BS)) begin
                mem_we    = 1'b1;
                mem_waddr = cursor_xy - 8'd1;
            end
        end
    end

    // Whole-cursor increments give col/row carry and 0xFF->0x00 wrap for free
    always_comb begin
        cursor_nxt = cursor_xy;
        if (accept) begin
            if (is_printable(wr_char)) begin
                cursor_nxt = cursor_xy + 8'd1;
            end else begin
                case (wr_char)
                    CC_LF:   cursor_nxt = {cursor_xy[7:4] + 4'd1, 4'h0};
                    CC_CR:   cursor_nxt = {cursor_xy[7:4], 4'h0};
                    CC_BS:   cursor_nxt = cursor_xy - 8'd1;
                    CC_HT:   cursor_nxt = (cursor_xy | TAB_MASK) + 8'd1;
                    default: cursor_nxt = cursor_xy;
                endcase
            end
        end
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state     <= CLEAR;
            clr_addr  <= 8'h00;
            cursor_xy <= 8'h00;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + 8'd1;
            if (clr_addr == 8'hFF) begin
                state     <= IDLE;
                cursor_xy <= 8'h00;
            end
        end else begin
            cursor_xy <= cursor_nxt;
            if (accept && (wr_char == CC_FF)) begin
                state    <= CLEAR;
                clr_addr <= 8'h00;
            end
        end
    end

    always_ff @(posedge clk65MHz) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Asynchronous read: same-cell write lands after this clock's sample
    assign font_code = mem[char_xy][6:0];

    font_rom u_font (
        .addr ({font_code, char_line}),
        .data (font_row)
    );

    always_ff @(posedge clk65MHz) begin
        if (rst)
            char_pixel <= '0;
        else
            char_pixel <= font_row;
    end

endmodule

// File: tb/tb_char_text_buffer.sv
// Randomised scoreboard bench for char_text_buffer.
// A row/column text model predicts pixels, cursor, busy and ready per clock.
module tb_char_text_buffer;

    localparam logic [7:0] FILL = 8'h20;
    localparam int K_PIX = 0;
    localparam int K_CUR = 1;
    localparam int K_BSY = 2;
    localparam int K_RDY = 3;

    logic       clk65MHz = 1'b0;
    logic       rst;
    logic [7:0] char_xy;
    logic [3:0] char_line;
    logic [7:0] char_pixel;
    logic       wr_valid;
    logic [7:0] wr_char;
    logic       wr_ready;
    logic [7:0] cursor_xy;
    logic       busy;

    logic [10:0] ref_addr = '0;
    logic [7:0]  ref_data;

    typedef struct {
        int         due;
        int         kind;
        logic [7:0] val;
    } sb_item_t;

    sb_item_t sb[$];
    sb_item_t e;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    int ram_m [256];
    int cur_row;
    int cur_col;
    int clear_left;

    char_text_buffer dut (
        .clk65MHz   (clk65MHz),
        .rst        (rst),
        .char_xy    (char_xy),
        .char_line  (char_line),
        .char_pixel (char_pixel),
        .wr_valid   (wr_valid),
        .wr_char    (wr_char),
        .wr_ready   (wr_ready),
        .cursor_xy  (cursor_xy),
        .busy       (busy)
    );

    // Glyph table used as the reference font
    font_rom u_ref (
        .addr (ref_addr),
        .data (ref_data)
    );

    always #5 clk65MHz = ~clk65MHz;

    always @(posedge clk65MHz) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            K_PIX:   return "char_pixel";
            K_CUR:   return "cursor_xy";
            K_BSY:   return "busy";
            default: return "wr_ready";
        endcase
    endfunction

    always @(negedge clk65MHz) begin
        logic [7:0] act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_PIX:   act = char_pixel;
                K_CUR:   act = cursor_xy;
                K_BSY:   act = {7'b0, busy};
                default: act = {7'b0, wr_ready};
            endcase
            checks++;
            if (act !== e.val || e.due != cyc) begin
                failures++;
                $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h",
                         kind_name(e.kind), cyc, e.due, act, e.val);
            end
        end
    end

    task automatic push(input int kind, input logic [7:0] val);
        sb_item_t it;
        it.due  = cyc + 1;
        it.kind = kind;
        it.val  = val;
        sb.push_back(it);
    endtask

    task automatic glyph(input logic [7:0] code, input logic [3:0] ln,
                         output logic [7:0] row);
        ref_addr = {code[6:0], ln};
        #1;
        row = ref_data;
    endtask

    function automatic logic [7:0] cur_byte();
        return 8'(cur_row * 16 + cur_col);
    endfunction

    task automatic apply_byte(input logic [7:0] ch);
        int idx;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            ram_m[cur_row * 16 + cur_col] = int'(ch);
            idx = (cur_row * 16 + cur_col + 1) % 256;
            cur_row = idx / 16;
            cur_col = idx % 16;
        end else if (ch == 8'h0A) begin
            cur_row = (cur_row + 1) % 16;
            cur_col = 0;
        end else if (ch == 8'h0D) begin
            cur_col = 0;
        end else if (ch == 8'h08) begin
            idx = (cur_row * 16 + cur_col + 255) % 256;
            cur_row = idx / 16;
            cur_col = idx % 16;
            ram_m[idx] = int'(FILL);
        end else if (ch == 8'h09) begin
            cur_col = (cur_col / 4 + 1) * 4;
            if (cur_col >= 16) begin
                cur_col = 0;
                cur_row = (cur_row + 1) % 16;
            end
        end else if (ch == 8'h0C) begin
            clear_left = 256;
        end
    endtask

    task automatic model(input bit r, input bit v, input logic [7:0] ch,
                         input logic [7:0] xy, input logic [3:0] ln);
        logic [7:0] row;
        if (r) begin
            clear_left = 256;
            cur_row = 0;
            cur_col = 0;
            push(K_PIX, 8'h00);
            push(K_CUR, 8'h00);
            push(K_BSY, 8'h01);
            push(K_RDY, 8'h00);
            return;
        end
        if (ram_m[xy] >= 0) begin
            glyph(8'(ram_m[xy]), ln, row);
            push(K_PIX, row);
        end
        if (clear_left > 0) begin
            ram_m[256 - clear_left] = int'(FILL);
            clear_left--;
            if (clear_left == 0) begin
                cur_row = 0;
                cur_col = 0;
            end
        end else if (v) begin
            apply_byte(ch);
        end
        push(K_CUR, cur_byte());
        push(K_BSY, (clear_left > 0) ? 8'h01 : 8'h00);
        push(K_RDY, (clear_left == 0) ? 8'h01 : 8'h00);
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] ch,
                        input logic [7:0] xy, input logic [3:0] ln);
        rst       = r;
        wr_valid  = v;
        wr_char   = ch;
        char_xy   = xy;
        char_line = ln;
        model(r, v, ch, xy, ln);
        @(posedge clk65MHz);
        #1;
    endtask

    task automatic wr(input logic [7:0] ch);
        step(1'b0, 1'b1, ch, 8'($urandom), 4'($urandom));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'($urandom), 4'($urandom));
    endtask

    function automatic logic [7:0] rand_char();
        int p;
        p = int'($urandom_range(0, 99));
        if (p < 60) return 8'($urandom_range(8'h20, 8'h7E));
        if (p < 64) return 8'h0A;
        if (p < 67) return 8'h0D;
        if (p < 71) return 8'h08;
        if (p < 76) return 8'h09;
        if (p < 77) return 8'h0C;
        return 8'($urandom);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) ram_m[i] = -1;
        cur_row = 0;
        cur_col = 0;
        clear_left = 256;
        rst = 1'b1;
        wr_valid = 1'b0;
        wr_char = 8'h00;
        char_xy = 8'h00;
        char_line = 4'h0;
        @(posedge clk65MHz);
        #1;
        step(1'b1, 1'b0, 8'h00, 8'h00, 4'h0);
        step(1'b1, 1'b1, 8'h41, 8'h00, 4'h0);

        // Initial clear plus margin, then a full blank sweep
        repeat (300) idle();
        for (int i = 0; i < 4096; i++)
            step(1'b0, 1'b0, 8'h00, 8'(i >> 4), 4'(i));

        // 'A' at 0x00 read back on line 5
        step(1'b0, 1'b1, 8'h41, 8'h00, 4'd5);
        step(1'b0, 1'b0, 8'h00, 8'h00, 4'd5);
        step(1'b0, 1'b0, 8'h00, 8'h00, 4'd5);

        // Row wrap, LF, CR and tab stops
        wr(8'h0D);
        repeat (17) wr(8'h42);
        wr(8'h0A);
        repeat (10) wr(8'h2E);
        wr(8'h0D);
        wr(8'h2B);
        wr(8'h09);
        repeat (9) wr(8'h2D);
        wr(8'h09);

        // Last cell, wrap to 0x00, backspace back across the wrap
        repeat (12) wr(8'h0A);
        repeat (15) wr(8'h31);
        wr(8'h43);
        wr(8'h08);
        for (int l = 0; l < 16; l++)
            step(1'b0, 1'b0, 8'h00, 8'hFF, 4'(l));

        // Form feed held valid, then a stream of 'A'
        wr(8'h0C);
        repeat (260) wr(8'h41);

        // Same-cycle write and read of cell 0x33
        wr(8'h0D);
        repeat (3) wr(8'h0A);
        repeat (3) wr(8'h61);
        step(1'b0, 1'b1, 8'h5A, 8'h33, 4'd6);
        step(1'b0, 1'b0, 8'h00, 8'h33, 4'd6);
        step(1'b0, 1'b0, 8'h00, 8'h33, 4'd6);

        // Reset in the middle of a clear
        wr(8'h0C);
        repeat (100) idle();
        step(1'b1, 1'b1, 8'h41, 8'h00, 4'h0);
        repeat (270) idle();

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 999) == 0)
                step(1'b1, 1'($urandom), rand_char(), 8'($urandom), 4'($urandom));
            else
                step(1'b0, 1'($urandom_range(0, 3) != 0), rand_char(),
                     8'($urandom), 4'($urandom));
        end

        wr_valid = 1'b0;
        repeat (3) @(posedge clk65MHz);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
